// File: rtl/control_pkg.sv
// Shared definitions for the multicycle MIPS control unit.
//   - opcode constants for every supported instruction
//   - 4-bit state encoding of the control FSM
//   - ALU operation codes (3-bit, zero-extended by the top when wider)
//   - reg_dst, mem_to_reg, alu_src_b and pc_source mux encodings
//   - helper identifying the states that wait on the memory handshake
package control_pkg;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_ALU_WB   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_JAL      = 4'd11
  } state_t;

  localparam logic [2:0] ALU_ADD   = 3'b100;
  localparam logic [2:0] ALU_OR    = 3'b101;
  localparam logic [2:0] ALU_FUNCT = 3'b111;
  localparam logic [2:0] ALU_SUB   = 3'b001;

  localparam logic [1:0] REG_DST_RT = 2'b00;
  localparam logic [1:0] REG_DST_RD = 2'b01;
  localparam logic [1:0] REG_DST_RA = 2'b10;

  localparam logic [1:0] M2R_ALU = 2'b00;
  localparam logic [1:0] M2R_MDR = 2'b01;
  localparam logic [1:0] M2R_PC  = 2'b10;

  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // States that hold a memory strobe and stall until mem_ready.
  function automatic logic is_wait_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

endpackage

// File: rtl/wait_timer.sv
// Saturating counter of consecutive memory stall cycles.
//   clk    : rising-edge clock
//   reset  : asynchronous active-low reset, clears the count
//   clear  : synchronous clear (state change or abort)
//   stall  : current cycle is a memory wait with mem_ready low
//   expire : high in the TIMEOUT-th consecutive stall cycle; never high
//            when TIMEOUT is 0
module wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic stall,
  output logic expire
);

  localparam int W   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam int SAT = (TIMEOUT == 0) ? 1 : TIMEOUT;
  localparam int LST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam logic [W-1:0] SAT_V = W'(SAT);
  localparam logic [W-1:0] LST_V = W'(LST);
  localparam logic         EN    = (TIMEOUT != 0);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (stall && (cnt != SAT_V)) begin
      cnt <= cnt + W'(1);
    end
  end

  // cnt holds the number of earlier stall cycles, so the current stall is
  // the TIMEOUT-th one when cnt == TIMEOUT-1.
  assign expire = EN && stall && (cnt == LST_V);

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control unit: a Moore FSM sequencing fetch, decode,
// execute, memory and write-back, stalling on mem_ready.
//   clk, reset          : clock, asynchronous active-low reset
//   op                  : opcode from the IR, sampled in DECODE
//   mem_ready           : memory completes the current access this cycle
//   pc_write, branch_eq, branch_ne, pc_source : PC update controls
//   iord, mem_read, mem_write, ir_write       : memory / IR controls
//   reg_dst, mem_to_reg, reg_write            : register-file controls
//   alu_src_a, alu_src_b, alu_op              : ALU controls
//   illegal_op  : one-cycle pulse on an unsupported opcode
//   mem_timeout : sticky flag, set when a memory wait is aborted
//   instr_done  : pulse in the last cycle of each instruction
//   state       : current FSM state for observation
// Handshake: a memory strobe stays high in its state; the access completes
// in the cycle where the strobe and mem_ready are both high. mem_ready is
// ignored in every other state.
module multicycle_control
  import control_pkg::*;
#(
  parameter int ALUOP_W = 3,
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         op,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               branch_eq,
  output logic               branch_ne,
  output logic               iord,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic [1:0]         reg_dst,
  output logic [1:0]         mem_to_reg,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [ALUOP_W-1:0] alu_op,
  output logic [1:0]         pc_source,
  output logic               illegal_op,
  output logic               mem_timeout,
  output logic               instr_done,
  output state_t             state
);

  state_t cur_state, next_state;

  // Opcode-derived bits captured in DECODE for the later states.
  logic sel_sw, sel_bne, sel_ori, dst_rd;
  logic timeout_q;

  logic stall, expire, clear;
  logic [2:0] alu_code;
  logic pc_write_c, ir_write_c, reg_write_c, mem_write_c;
  logic instr_done_c, illegal_c;

  assign stall = is_wait_state(cur_state) && !mem_ready;
  assign clear = (next_state != cur_state) || expire;

  wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (clear),
    .stall  (stall),
    .expire (expire)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_state <= S_FETCH;
    end else begin
      cur_state <= next_state;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel_sw  <= 1'b0;
      sel_bne <= 1'b0;
      sel_ori <= 1'b0;
      dst_rd  <= 1'b0;
    end else if (cur_state == S_DECODE) begin
      sel_sw  <= (op == OP_SW);
      sel_bne <= (op == OP_BNE);
      sel_ori <= (op == OP_ORI);
      dst_rd  <= (op == OP_R);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timeout_q <= 1'b0;
    end else if (expire) begin
      timeout_q <= 1'b1;
    end
  end

  always_comb begin
    next_state   = cur_state;
    pc_write_c   = 1'b0;
    ir_write_c   = 1'b0;
    reg_write_c  = 1'b0;
    mem_write_c  = 1'b0;
    instr_done_c = 1'b0;
    illegal_c    = 1'b0;
    branch_eq    = 1'b0;
    branch_ne    = 1'b0;
    iord         = 1'b0;
    mem_read     = 1'b0;
    reg_dst      = REG_DST_RT;
    mem_to_reg   = M2R_ALU;
    alu_src_a    = 1'b0;
    alu_src_b    = SRCB_RT;
    alu_code     = 3'b000;
    pc_source    = PCSRC_ALU;

    case (cur_state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        alu_code  = ALU_ADD;
        if (mem_ready) begin
          pc_write_c = 1'b1;
          ir_write_c = 1'b1;
          next_state = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMM_SH;
        alu_code  = ALU_ADD;
        case (op)
          OP_LW, OP_SW:    next_state = S_MEM_ADDR;
          OP_R:            next_state = S_EXEC_R;
          OP_ADDI, OP_ORI: next_state = S_EXEC_I;
          OP_BEQ, OP_BNE:  next_state = S_BRANCH;
          OP_J:            next_state = S_JUMP;
          OP_JAL:          next_state = S_JAL;
          default: begin
            illegal_c    = 1'b1;
            instr_done_c = 1'b1;
            next_state   = S_FETCH;
          end
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_IMM;
        alu_code   = ALU_ADD;
        next_state = sel_sw ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (mem_ready) next_state = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_write_c  = 1'b1;
        reg_dst      = REG_DST_RT;
        mem_to_reg   = M2R_MDR;
        instr_done_c = 1'b1;
        next_state   = S_FETCH;
      end
      S_MEM_WR: begin
        mem_write_c = 1'b1;
        iord        = 1'b1;
        if (mem_ready) begin
          instr_done_c = 1'b1;
          next_state   = S_FETCH;
        end
      end
      S_EXEC_R: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_RT;
        alu_code   = ALU_FUNCT;
        next_state = S_ALU_WB;
      end
      S_EXEC_I: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_IMM;
        alu_code   = sel_ori ? ALU_OR : ALU_ADD;
        next_state = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write_c  = 1'b1;
        reg_dst      = dst_rd ? REG_DST_RD : REG_DST_RT;
        mem_to_reg   = M2R_ALU;
        instr_done_c = 1'b1;
        next_state   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a    = 1'b1;
        alu_src_b    = SRCB_RT;
        alu_code     = ALU_SUB;
        pc_source    = PCSRC_ALUOUT;
        branch_eq    = !sel_bne;
        branch_ne    = sel_bne;
        instr_done_c = 1'b1;
        next_state   = S_FETCH;
      end
      S_JUMP: begin
        pc_write_c   = 1'b1;
        pc_source    = PCSRC_JUMP;
        instr_done_c = 1'b1;
        next_state   = S_FETCH;
      end
      S_JAL: begin
        pc_write_c   = 1'b1;
        pc_source    = PCSRC_JUMP;
        reg_write_c  = 1'b1;
        reg_dst      = REG_DST_RA;
        mem_to_reg   = M2R_PC;
        instr_done_c = 1'b1;
        next_state   = S_FETCH;
      end
      default: begin
        next_state = S_FETCH;
      end
    endcase

    // Aborted memory wait: end the instruction without committing anything.
    if (expire) begin
      next_state   = S_FETCH;
      instr_done_c = 1'b1;
      pc_write_c   = 1'b0;
      ir_write_c   = 1'b0;
      reg_write_c  = 1'b0;
    end
  end

  // Architectural enables are gated by reset directly so they drop the
  // moment reset asserts; the state register already shows FETCH then.
  assign pc_write    = pc_write_c   & reset;
  assign ir_write    = ir_write_c   & reset;
  assign reg_write   = reg_write_c  & reset;
  assign mem_write   = mem_write_c  & reset;
  assign instr_done  = instr_done_c & reset;
  assign illegal_op  = illegal_c    & reset;
  assign alu_op      = ALUOP_W'(alu_code);
  assign mem_timeout = timeout_q;
  assign state       = cur_state;

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;
  import control_pkg::*;

  logic       clk;
  logic       reset;
  logic [5:0] op;
  logic       mem_ready;
  logic       pc_write, branch_eq, branch_ne, iord, mem_read, mem_write;
  logic       ir_write, reg_write, alu_src_a, illegal_op, mem_timeout, instr_done;
  logic [1:0] reg_dst, mem_to_reg, alu_src_b, pc_source;
  logic [2:0] alu_op;
  state_t     dbg_state;

  int tests_run = 0;
  int tests_failed = 0;

  multicycle_control #(.ALUOP_W(3), .TIMEOUT(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .op          (op),
    .mem_ready   (mem_ready),
    .pc_write    (pc_write),
    .branch_eq   (branch_eq),
    .branch_ne   (branch_ne),
    .iord        (iord),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .ir_write    (ir_write),
    .reg_dst     (reg_dst),
    .mem_to_reg  (mem_to_reg),
    .reg_write   (reg_write),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .alu_op      (alu_op),
    .pc_source   (pc_source),
    .illegal_op  (illegal_op),
    .mem_timeout (mem_timeout),
    .instr_done  (instr_done),
    .state       (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to the next cycle: inputs change at the falling edge, outputs
  // are sampled 1 time unit later, well before the next rising edge.
  task automatic cyc(input logic mr, input logic [5:0] o);
    @(negedge clk);
    mem_ready = mr;
    op = o;
    #1;
  endtask

  initial begin
    reset = 1'b0;
    mem_ready = 1'b1;
    op = 6'h00;
    repeat (2) @(negedge clk);
    #1;
    // held in reset with mem_ready high: FETCH values, enables forced low
    chk("rst_state", dbg_state, S_FETCH);
    chk("rst_mem_read", mem_read, 1'b1);
    chk("rst_alu_src_b", alu_src_b, 2'b01);
    chk("rst_pc_write", pc_write, 1'b0);
    chk("rst_ir_write", ir_write, 1'b0);
    chk("rst_instr_done", instr_done, 1'b0);
    chk("rst_timeout", mem_timeout, 1'b0);

    reset = 1'b1;
    #1;
    // R-type: FETCH, DECODE, EXEC_R, ALU_WB
    chk("r_c1_pc_write", pc_write, 1'b1);
    chk("r_c1_ir_write", ir_write, 1'b1);
    chk("r_c1_alu_op", alu_op, 3'b100);
    cyc(1'b0, OP_R);  // mem_ready low in DECODE must be ignored
    chk("r_c2_state", dbg_state, S_DECODE);
    chk("r_c2_alu_src_b", alu_src_b, 2'b11);
    chk("r_c2_done", instr_done, 1'b0);
    cyc(1'b1, 6'h3F);
    chk("r_c3_state", dbg_state, S_EXEC_R);
    chk("r_c3_alu_op", alu_op, 3'b111);
    chk("r_c3_alu_src_a", alu_src_a, 1'b1);
    chk("r_c3_done", instr_done, 1'b0);
    cyc(1'b1, 6'h00);
    chk("r_c4_state", dbg_state, S_ALU_WB);
    chk("r_c4_reg_write", reg_write, 1'b1);
    chk("r_c4_reg_dst", reg_dst, 2'b01);
    chk("r_c4_mem_to_reg", mem_to_reg, 2'b00);
    chk("r_c4_done", instr_done, 1'b1);
    cyc(1'b1, 6'h00);
    chk("r_next_state", dbg_state, S_FETCH);
    chk("r_next_done", instr_done, 1'b0);

    // LW with three stall cycles in MEM_RD (8 cycles total)
    cyc(1'b1, OP_LW);
    chk("lw_c2_state", dbg_state, S_DECODE);
    cyc(1'b1, 6'h00);
    chk("lw_c3_state", dbg_state, S_MEM_ADDR);
    chk("lw_c3_alu_src_b", alu_src_b, 2'b10);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 6'h00);
      chk("lw_stall_state", dbg_state, S_MEM_RD);
      chk("lw_stall_mem_read", mem_read, 1'b1);
      chk("lw_stall_iord", iord, 1'b1);
      chk("lw_stall_done", instr_done, 1'b0);
    end
    cyc(1'b1, 6'h00);
    chk("lw_c7_state", dbg_state, S_MEM_RD);
    chk("lw_c7_mem_read", mem_read, 1'b1);
    cyc(1'b1, 6'h00);
    chk("lw_c8_state", dbg_state, S_MEM_WB);
    chk("lw_c8_reg_write", reg_write, 1'b1);
    chk("lw_c8_mem_to_reg", mem_to_reg, 2'b01);
    chk("lw_c8_reg_dst", reg_dst, 2'b00);
    chk("lw_c8_done", instr_done, 1'b1);
    cyc(1'b1, 6'h00);
    chk("lw_next_state", dbg_state, S_FETCH);

    // BNE
    cyc(1'b1, OP_BNE);
    cyc(1'b1, 6'h00);
    chk("bne_state", dbg_state, S_BRANCH);
    chk("bne_branch_ne", branch_ne, 1'b1);
    chk("bne_branch_eq", branch_eq, 1'b0);
    chk("bne_alu_op", alu_op, 3'b001);
    chk("bne_pc_source", pc_source, 2'b01);
    chk("bne_pc_write", pc_write, 1'b0);
    chk("bne_done", instr_done, 1'b1);
    cyc(1'b1, 6'h00);
    chk("bne_next_state", dbg_state, S_FETCH);

    // BEQ
    cyc(1'b1, OP_BEQ);
    cyc(1'b1, 6'h00);
    chk("beq_branch_eq", branch_eq, 1'b1);
    chk("beq_branch_ne", branch_ne, 1'b0);

    // illegal opcode
    cyc(1'b1, 6'h3F);
    cyc(1'b1, 6'h3F);
    chk("ill_state", dbg_state, S_DECODE);
    chk("ill_pulse", illegal_op, 1'b1);
    chk("ill_done", instr_done, 1'b1);
    chk("ill_reg_write", reg_write, 1'b0);
    chk("ill_mem_write", mem_write, 1'b0);
    cyc(1'b1, 6'h00);
    chk("ill_next_state", dbg_state, S_FETCH);
    chk("ill_next_pulse", illegal_op, 1'b0);

    // ORI
    cyc(1'b1, OP_ORI);
    cyc(1'b1, 6'h00);
    chk("ori_state", dbg_state, S_EXEC_I);
    chk("ori_alu_op", alu_op, 3'b101);
    chk("ori_alu_src_b", alu_src_b, 2'b10);
    cyc(1'b1, 6'h00);
    chk("ori_reg_dst", reg_dst, 2'b00);
    chk("ori_reg_write", reg_write, 1'b1);

    // ADDI
    cyc(1'b1, 6'h00);
    cyc(1'b1, OP_ADDI);
    cyc(1'b1, 6'h00);
    chk("addi_alu_op", alu_op, 3'b100);
    cyc(1'b1, 6'h00);

    // JAL
    cyc(1'b1, 6'h00);
    cyc(1'b1, OP_JAL);
    cyc(1'b1, 6'h00);
    chk("jal_state", dbg_state, S_JAL);
    chk("jal_pc_write", pc_write, 1'b1);
    chk("jal_pc_source", pc_source, 2'b10);
    chk("jal_reg_dst", reg_dst, 2'b10);
    chk("jal_mem_to_reg", mem_to_reg, 2'b10);
    chk("jal_reg_write", reg_write, 1'b1);

    // J
    cyc(1'b1, 6'h00);
    cyc(1'b1, OP_J);
    cyc(1'b1, 6'h00);
    chk("j_state", dbg_state, S_JUMP);
    chk("j_reg_write", reg_write, 1'b0);
    chk("j_done", instr_done, 1'b1);

    // SW with memory stuck: abort in the 4th stall cycle
    cyc(1'b1, 6'h00);
    cyc(1'b1, OP_SW);
    cyc(1'b1, 6'h00);
    chk("sw_addr_state", dbg_state, S_MEM_ADDR);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 6'h00);
      chk("sw_stall_state", dbg_state, S_MEM_WR);
      chk("sw_stall_mem_write", mem_write, 1'b1);
      chk("sw_stall_done", instr_done, 1'b0);
      chk("sw_stall_timeout", mem_timeout, 1'b0);
    end
    cyc(1'b0, 6'h00);
    chk("sw_abort_done", instr_done, 1'b1);
    chk("sw_abort_timeout", mem_timeout, 1'b0);
    cyc(1'b1, 6'h00);
    chk("sw_after_state", dbg_state, S_FETCH);
    chk("sw_after_timeout", mem_timeout, 1'b1);
    // flag is sticky across a normal instruction
    cyc(1'b1, OP_R);
    cyc(1'b1, 6'h00);
    cyc(1'b1, 6'h00);
    chk("sticky_done", instr_done, 1'b1);
    cyc(1'b1, 6'h00);
    chk("sticky_timeout", mem_timeout, 1'b1);

    // reset in the middle of a MEM_WR stall
    cyc(1'b1, OP_SW);
    cyc(1'b1, 6'h00);
    cyc(1'b0, 6'h00);
    cyc(1'b0, 6'h00);
    chk("mid_pre_state", dbg_state, S_MEM_WR);
    chk("mid_pre_mem_write", mem_write, 1'b1);
    reset = 1'b0;
    #1;
    chk("mid_rst_state", dbg_state, S_FETCH);
    chk("mid_rst_mem_write", mem_write, 1'b0);
    chk("mid_rst_mem_read", mem_read, 1'b1);
    chk("mid_rst_iord", iord, 1'b0);
    chk("mid_rst_timeout", mem_timeout, 1'b0);
    reset = 1'b1;
    #1;
    // counter must start from zero: abort exactly on the 4th FETCH stall
    chk("fs1_done", instr_done, 1'b0);
    for (int i = 0; i < 2; i++) begin
      cyc(1'b0, 6'h00);
      chk("fs_state", dbg_state, S_FETCH);
      chk("fs_done", instr_done, 1'b0);
    end
    cyc(1'b0, 6'h00);
    chk("fs4_done", instr_done, 1'b1);
    chk("fs4_pc_write", pc_write, 1'b0);
    cyc(1'b1, 6'h00);
    chk("fs_after_timeout", mem_timeout, 1'b1);
    chk("fs_after_pc_write", pc_write, 1'b1);
    chk("fs_after_done", instr_done, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
